// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner with a per-digit register file,
// anti-ghost blanking and leading-zero suppression.
// Optional blink support is compiled in with the SEG7_BLINK_EN macro.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 8,
  parameter int COM_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 0
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV   = 5000
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] i_wr_addr,
  input  logic [4:0]                    i_wr_data,
  input  logic [NUM_DIGITS-1:0]         i_digit_en,
  input  logic                          i_lz_sup,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         i_blink_mask,
`endif
  output logic [7:0]                    o_seg_d,
  output logic [NUM_DIGITS-1:0]         o_seg_com,
  output logic                          o_frame_tick
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]         PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]         PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [AW-1:0]         IDX_LAST  = AW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF   = {8{SEG_ACT_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] COM_OFF   = {NUM_DIGITS{COM_ACT_LOW != 0}};

  logic [PW-1:0]         pres_q, pres_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  tick_q, tick_d;
  logic [4:0]            digit_q [NUM_DIGITS];
  logic [4:0]            digit_d [NUM_DIGITS];
  logic [7:0]            seg_q, seg_d, seg_raw;
  logic [NUM_DIGITS-1:0] com_q, com_d, com_raw;
  logic [NUM_DIGITS-1:0] nz_en, lz_blank;
  logic [4:0]            cur;
  logic                  blink_dark;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Slot prescaler, digit index walk, frame tick and register-file writes
  always_comb begin
    pres_d = pres_q + PW'(1);
    idx_d  = idx_q;
    tick_d = 1'b0;
    if (pres_q == PRE_LAST) begin
      pres_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d  = '0;
        tick_d = 1'b1;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
    // Per-digit address match: addresses at or above NUM_DIGITS hit nothing
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = digit_q[i];
      if (i_wr_en && (i_wr_addr == AW'(i))) digit_d[i] = i_wr_data;
    end
  end

  // Leading-zero map: digit blanks if it and every enabled digit above it hold hex 0
  always_comb begin
    nz_en    = '0;
    lz_blank = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      nz_en[i] = i_digit_en[i] & (digit_q[i][3:0] != 4'h0);
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      lz_blank[i] = (i != 0) && (digit_q[i][3:0] == 4'h0) && ((nz_en >> (i + 1)) == '0);
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(BLINK_DIV - 1);

  logic [FW-1:0] fc_q, fc_d;
  logic          ph_q, ph_d;

  // Count frames and flip the blink phase every BLINK_DIV frames
  always_comb begin
    fc_d = fc_q;
    ph_d = ph_q;
    if (tick_q) begin
      if (fc_q == FC_LAST) begin
        fc_d = '0;
        ph_d = ~ph_q;
      end else begin
        fc_d = fc_q + FW'(1);
      end
    end
  end

  // Blink state registers; phase 0 (lit) after reset
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fc_q <= '0;
      ph_q <= 1'b0;
    end else begin
      fc_q <= fc_d;
      ph_q <= ph_d;
    end
  end

  assign blink_dark = ph_q & i_blink_mask[idx_q];
`else
  assign blink_dark = 1'b0;
`endif

  // Pin values for the current slot, polarity applied last
  always_comb begin
    cur     = digit_q[idx_q];
    seg_raw = 8'h00;
    com_raw = '0;
    if ((pres_q >= PRE_BLANK) && i_digit_en[idx_q]) begin
      com_raw = NUM_DIGITS'(1) << idx_q;
      seg_raw = {cur[4], (i_lz_sup && lz_blank[idx_q]) ? 7'h00 : hex7(cur[3:0])};
      if (blink_dark) seg_raw = 8'h00;
    end
    seg_d = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
    com_d = (COM_ACT_LOW != 0) ? ~com_raw : com_raw;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pres_q <= '0;
      idx_q  <= '0;
      tick_q <= 1'b0;
      seg_q  <= SEG_OFF;
      com_q  <= COM_OFF;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      pres_q <= pres_d;
      idx_q  <= idx_d;
      tick_q <= tick_d;
      seg_q  <= seg_d;
      com_q  <= com_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign o_seg_d      = seg_q;
  assign o_seg_com    = com_q;
  assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (N=8, SCAN_DIV=16, BLANK_CYC=2, 10 MHz).
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
  localparam int N  = 8;
  localparam int SD = 16;
  localparam int BC = 2;
`ifdef SEG7_BLINK_EN
  localparam int BD = 2;
`endif

  logic       clk = 1'b0, rstn = 1'b0, wr_en = 1'b0, lz_sup = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [7:0] digit_en = 8'hFF;
`ifdef SEG7_BLINK_EN
  logic [7:0] blink_mask = 8'h01;
`endif
  logic [7:0] seg, com;
  logic       tick;

  int checks = 0, errors = 0;

  always #50 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .COM_ACT_LOW(1), .SEG_ACT_LOW(0)
`ifdef SEG7_BLINK_EN
    , .BLINK_DIV(BD)
`endif
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_digit_en(digit_en), .i_lz_sup(lz_sup),
`ifdef SEG7_BLINK_EN
    .i_blink_mask(blink_mask),
`endif
    .o_seg_d(seg), .o_seg_com(com), .o_frame_tick(tick)
  );

  // Behavioural model: position in time is just the count of clocks since reset release
  logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [4:0] mreg [N];
  int         n = 0;
`ifdef SEG7_BLINK_EN
  int         ticks = 0;
`endif
  logic [7:0] exp_seg = 8'h00, exp_com = 8'hFF;
  logic       exp_tick = 1'b0;

  function automatic logic lz_off(input int k);
    if (k == 0 || mreg[k][3:0] != 4'h0) return 1'b0;
    for (int j = k + 1; j < N; j++)
      if (digit_en[j] && mreg[j][3:0] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n = 0;
`ifdef SEG7_BLINK_EN
      ticks = 0;
`endif
      exp_seg = 8'h00; exp_com = 8'hFF; exp_tick = 1'b0;
      for (int i = 0; i < N; i++) mreg[i] = 5'h00;
    end else begin
      int pres, idx;
      logic [7:0] s, c;
      pres = n % SD;
      idx  = (n / SD) % N;
      s = 8'h00; c = 8'h00;
      if (pres >= BC && digit_en[idx]) begin
        c[idx] = 1'b1;
        s = {mreg[idx][4], (lz_sup && lz_off(idx)) ? 7'h00 : SEGTAB[mreg[idx][3:0]]};
`ifdef SEG7_BLINK_EN
        if (((ticks / BD) % 2) == 1 && blink_mask[idx]) s = 8'h00;
        if (exp_tick) ticks++;
`endif
      end
`ifdef SEG7_BLINK_EN
      else if (exp_tick) ticks++;
`endif
      exp_seg  = s;
      exp_com  = ~c;
      exp_tick = (pres == SD - 1) && (idx == N - 1);
      if (wr_en) mreg[wr_addr] = wr_data;
      n++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("seg", {24'h0, seg}, {24'h0, exp_seg});
    chk("com", {24'h0, com}, {24'h0, exp_com});
    chk("tick", {31'h0, tick}, {31'h0, exp_tick});
  end

  // Return at the negedge where the pins show slot idx at prescaler value p
  task automatic wait_out(input int idx, input int p);
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (n > 0 && (n - 1) % SD == p && ((n - 1) / SD) % N == idx) return;
    end
    checks++; errors++;
    $display("FAIL wait_out: slot %0d/%0d not reached, required within 2000 cycles", idx, p);
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic tick_period(input string nm);
    int cnt;
    cnt = 0;
    while (tick !== 1'b1 && cnt < 300) begin @(negedge clk); cnt++; end
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (tick !== 1'b1 && cnt < 300);
    chk(nm, cnt, 128);
  endtask

  initial begin
    // Reset held 1 us
    repeat (10) @(negedge clk);
    chk("rst_com", {24'h0, com}, 32'hFF);
    chk("rst_seg", {24'h0, seg}, 32'h00);
    chk("rst_tick", {31'h0, tick}, 32'h0);
    rstn = 1'b1;
    for (int k = 1; k <= BC + 1; k++) begin
      @(negedge clk);
      chk("first_com", {24'h0, com}, (k <= BC) ? 32'hFF : 32'hFE);
    end

    // Counting digits 0..7
    for (int a = 0; a < N; a++) wr(3'(a), 5'(a));
    wait_out(2, BC + 3);
    chk("d2_seg", {24'h0, seg}, 32'h5B);
    chk("d2_com", {24'h0, com}, 32'hFB);
    wait_out(7, BC);
    chk("d7_seg", {24'h0, seg}, 32'h07);
    chk("d7_com", {24'h0, com}, 32'h7F);
    tick_period("tick_period");

    // Leading-zero suppression
    lz_sup = 1'b1;
    for (int a = 7; a >= 3; a--) wr(3'(a), 5'h00);
    wr(3'd2, 5'h01); wr(3'd1, 5'h02); wr(3'd0, 5'h03);
    wait_out(5, BC + 1);
    chk("lz_d5_seg", {24'h0, seg}, 32'h00);
    chk("lz_d5_com", {24'h0, com}, 32'hDF);
    wait_out(2, BC + 1);
    chk("lz_d2_seg", {24'h0, seg}, 32'h06);
    wr(3'd3, 5'h10);
    wait_out(3, BC + 1);
    chk("lz_dp_seg", {24'h0, seg}, 32'h80);

    // Digit enables
    digit_en = 8'h0F;
    wait_out(5, BC + 4);
    chk("en_d5_com", {24'h0, com}, 32'hFF);
    chk("en_d5_seg", {24'h0, seg}, 32'h00);
    wait_out(1, BC + 4);
    chk("en_d1_com", {24'h0, com}, 32'hFD);
    tick_period("tick_period_en");
    digit_en = 8'hFF;

    // Mid-slot write shows within two cycles
    wait_out(2, 4);
    wr(3'd2, 5'h1A);
    @(negedge clk);
    chk("midslot_seg", {24'h0, seg}, 32'hF7);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      wr_en   = ($urandom % 3 == 0);
      wr_addr = 3'($urandom % 8);
      wr_data = {($urandom % 4 == 0), ($urandom % 2 == 0) ? 4'h0 : 4'($urandom)};
      if ($urandom % 50 == 0) digit_en = 8'($urandom);
      if ($urandom % 100 == 0) lz_sup = 1'($urandom);
    end
    wr_en = 1'b0;

`ifdef SEG7_BLINK_EN
    // Blink: digit 0 lit two frames, dark two frames
    digit_en = 8'hFF; lz_sup = 1'b0;
    @(negedge clk); #5 rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    wr(3'd0, 5'h08);
    wait_out(0, BC + 1);
    chk("blink_lit", {24'h0, seg}, 32'h7F);
    repeat (2 * N * SD) @(negedge clk);
    chk("blink_dark", {24'h0, seg}, 32'h00);
    chk("blink_dark_com", {24'h0, com}, 32'hFE);
    #5 rstn = 1'b0;
    #1 chk("blink_rst_com", {24'h0, com}, 32'hFF);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wr(3'd0, 5'h08);
    wait_out(0, BC + 1);
    chk("blink_after_rst", {24'h0, seg}, 32'h7F);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
